gate_sweep_ctrl: RTL and testbench

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

---
 rtl/gate_sweep_ctrl_if.sv | 28 ++
 rtl/gate_sweep_ctrl.sv | 127 ++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// Bus between the truth-table sweep controller, its host and the gate under test.
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic                   abort;
    logic [2**N_IN-1:0]     exp_table;
    logic                   dut_y;
    logic [N_IN-1:0]        vec_out;
    logic                   busy;
    logic                   done;
    logic                   sample_valid;
    logic [2**N_IN-1:0]     truth_table;
    logic [N_IN:0]          mismatch_cnt;
    logic                   pass;

    // Host side: requests sweeps, supplies expectations and the gate response.
    modport master (
        output start, abort, exp_table, dut_y,
        input  vec_out, busy, done, sample_valid, truth_table, mismatch_cnt, pass
    );

    // Controller side.
    modport slave (
        input  start, abort, exp_table, dut_y,
        output vec_out, busy, done, sample_valid, truth_table, mismatch_cnt, pass
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller: walks every input vector of a small gate,
// waits SETTLE cycles per vector, captures the gate output and compares it
// against an expected table. Status outputs decode the state register only,
// so no input reaches an output without passing through a flop.
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input logic              clk,
    input logic              rst,
    gate_sweep_ctrl_if.slave bus
);
    localparam int N_VEC = 2 ** N_IN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic [N_IN-1:0]  vec;
    logic [N_VEC-1:0] table_q;
    logic [N_IN:0]    miss_cnt;
    logic             pass_q;

    logic accept;
    logic last_vec;
    logic settle_end;
    logic miss;

    // A start is only honoured from a resting state and never alongside abort.
    assign accept     = bus.start && !bus.abort && (state == ST_IDLE || state == ST_DONE);
    assign last_vec   = &vec;
    assign settle_end = (settle_cnt == 4'(SETTLE - 1));
    assign miss       = (bus.dut_y != bus.exp_table[vec]);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort outranks start and every sweep transition.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (bus.abort)       state_nxt = ST_IDLE;
                else if (settle_end) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.abort)     state_nxt = ST_IDLE;
                else if (last_vec) state_nxt = ST_DONE;
                else               state_nxt = ST_SETTLE;
            end
            ST_DONE: begin
                if (bus.abort)   state_nxt = ST_IDLE;
                else if (accept) state_nxt = ST_SETTLE;
            end
            default:             state_nxt = ST_IDLE;
        endcase
    end

    // Vector counter, settle timer and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            table_q    <= '0;
            miss_cnt   <= '0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE && bus.abort) begin
                        // Leaving DONE by abort drops the verdict but keeps the results.
                        vec    <= '0;
                        pass_q <= 1'b0;
                    end else if (accept) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        table_q    <= '0;
                        miss_cnt   <= '0;
                        pass_q     <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    settle_cnt <= '0;
                    if (bus.abort) begin
                        // An aborted sample leaves the partial results untouched.
                        vec <= '0;
                    end else begin
                        table_q[vec] <= bus.dut_y;
                        if (miss) miss_cnt <= miss_cnt + (N_IN + 1)'(1);
                        // Verdict folds in this final sample; vec_out parks at all-ones.
                        if (last_vec) pass_q <= (miss_cnt == '0) && !miss;
                        else          vec    <= vec + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vec_out      = vec;
    assign bus.busy         = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign bus.done         = (state == ST_DONE);
    assign bus.sample_valid = (state == ST_SAMPLE);
    assign bus.truth_table  = table_q;
    assign bus.mismatch_cnt = miss_cnt;
    assign bus.pass         = pass_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: table-driven sweeps, hand-written
// abort/reset/restart sequences, a SETTLE=3 instance, and random gate tables
// scored against a popcount reference.
module tb_gate_sweep_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gate_sweep_ctrl_if #(.N_IN(2)) a_if ();
    gate_sweep_ctrl_if #(.N_IN(2)) b_if ();

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    always #5 clk = ~clk;

    // Gate under test for dut_a: AND built from NOR gates, or an arbitrary table.
    logic       gate_sel;
    logic [3:0] gate_tbl;
    logic       na;
    logic       nb;
    logic       nor_and;
    assign na          = ~(a_if.vec_out[0] | a_if.vec_out[0]);
    assign nb          = ~(a_if.vec_out[1] | a_if.vec_out[1]);
    assign nor_and     = ~(na | nb);
    assign a_if.dut_y  = gate_sel ? gate_tbl[a_if.vec_out] : nor_and;

    logic [3:0] b_tbl;
    assign b_if.dut_y = b_tbl[b_if.vec_out];

    typedef struct {
        logic [3:0] et;
        logic       sel;
        logic [3:0] tbl;
        logic [3:0] exp_tt;
        logic [2:0] exp_mm;
        logic       exp_pass;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep on dut_a; returns latency, strobe count, sampled vector order
    // and a snapshot of the outputs just after the accepting edge.
    task automatic sweep_a(input logic [3:0] et, input logic sel, input logic [3:0] tbl,
                           output int lat, output int pulses, output logic [7:0] seq,
                           output logic [11:0] snap);
        lat      = 0;
        pulses   = 0;
        seq      = '0;
        a_if.exp_table = et;
        gate_sel = sel;
        gate_tbl = tbl;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        snap = {a_if.done, a_if.busy, a_if.truth_table, a_if.mismatch_cnt, a_if.pass, a_if.vec_out};
        while (!a_if.done && lat < 100) begin
            if (a_if.sample_valid) begin
                if (pulses < 4) seq[2*pulses +: 2] = a_if.vec_out;
                pulses++;
            end
            tick();
            lat++;
        end
    endtask

    task automatic wait_a_idle_state(input int budget);
        for (int k = 0; k < budget && !a_if.done; k++) tick();
    endtask

    initial begin
        int         lat;
        int         pulses;
        logic [7:0] seq;
        logic [11:0] snap;
        int         holds [4];
        int         k;
        logic [3:0] rt;
        logic [3:0] re;

        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.exp_table = '0;
        b_if.start = 1'b0; b_if.abort = 1'b0; b_if.exp_table = '0;
        gate_sel = 1'b0; gate_tbl = '0; b_tbl = '0;

        vecs[0] = '{4'b1000, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b1};
        vecs[1] = '{4'b0001, 1'b0, 4'b0000, 4'b1000, 3'd2, 1'b0};
        vecs[2] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 3'd4, 1'b0};
        vecs[3] = '{4'b0110, 1'b1, 4'b0110, 4'b0110, 3'd0, 1'b1};
        vecs[4] = '{4'b1000, 1'b0, 4'b0000, 4'b1000, 3'd0, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs",
              {a_if.vec_out, a_if.busy, a_if.done, a_if.sample_valid,
               a_if.truth_table, a_if.mismatch_cnt, a_if.pass}, 32'd0);

        // Table-driven sweeps; entries after the first restart straight from DONE.
        for (int i = 0; i < 5; i++) begin
            sweep_a(vecs[i].et, vecs[i].sel, vecs[i].tbl, lat, pulses, seq, snap);
            check($sformatf("t%0d_accept_snapshot", i), snap, 12'h400);
            check($sformatf("t%0d_latency", i), lat, 8);
            check($sformatf("t%0d_pulses", i), pulses, 4);
            check($sformatf("t%0d_vec_order", i), seq, 8'hE4);
            check($sformatf("t%0d_truth_table", i), a_if.truth_table, vecs[i].exp_tt);
            check($sformatf("t%0d_mismatch", i), a_if.mismatch_cnt, vecs[i].exp_mm);
            check($sformatf("t%0d_pass", i), a_if.pass, vecs[i].exp_pass);
            check($sformatf("t%0d_done_busy", i), {a_if.done, a_if.busy}, 2'b10);
        end

        // Abort + start together in DONE: abort wins, verdict dropped.
        a_if.abort = 1'b1; a_if.start = 1'b1;
        tick();
        check("abort_done", {a_if.done, a_if.busy, a_if.pass}, 3'b000);
        check("abort_done_keeps_tt", a_if.truth_table, 4'b1000);
        // Same pair in IDLE: nothing starts.
        tick();
        check("abort_start_idle", {a_if.done, a_if.busy}, 2'b00);
        a_if.abort = 1'b0; a_if.start = 1'b0;

        // Abort in the SAMPLE cycle of vector 2.
        a_if.exp_table = 4'b0101; gate_sel = 1'b1; gate_tbl = 4'b1111;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (k = 0; k < 20 && !(a_if.sample_valid && a_if.vec_out == 2'd2); k++) tick();
        check("reach_sample_v2", k < 20, 1'b1);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        check("abort_sample_state",
              {a_if.busy, a_if.done, a_if.sample_valid, a_if.pass, a_if.vec_out}, 6'd0);
        check("abort_partial_tt", a_if.truth_table, 4'b0011);
        check("abort_partial_mm", a_if.mismatch_cnt, 3'd1);
        tick();
        check("idle_retains_tt", {a_if.truth_table, a_if.mismatch_cnt}, {4'b0011, 3'd1});
        sweep_a(4'b0101, 1'b1, 4'b1111, lat, pulses, seq, snap);
        check("restart_snapshot", snap, 12'h400);
        check("restart_result", {a_if.truth_table, a_if.mismatch_cnt, a_if.pass, lat[7:0]},
              {4'b1111, 3'd2, 1'b0, 8'd8});

        // Reset during SETTLE of vector 1, with start held alongside it.
        a_if.exp_table = 4'b0000; gate_tbl = 4'b1111;
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        for (k = 0; k < 20 && !(a_if.busy && !a_if.sample_valid && a_if.vec_out == 2'd1); k++) tick();
        check("reach_settle_v1", k < 20, 1'b1);
        rst = 1'b1; a_if.start = 1'b1;
        tick();
        check("midsweep_reset",
              {a_if.vec_out, a_if.busy, a_if.done, a_if.sample_valid,
               a_if.truth_table, a_if.mismatch_cnt, a_if.pass}, 32'd0);
        rst = 1'b0; a_if.start = 1'b0;
        tick();
        check("start_with_rst_ignored", {a_if.busy, a_if.done}, 2'b00);
        a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        check("start_after_rst", {a_if.busy, a_if.vec_out}, 3'b100);
        wait_a_idle_state(40);
        check("post_reset_sweep", {a_if.done, a_if.truth_table, a_if.mismatch_cnt}, {1'b1, 4'b1111, 3'd4});

        // SETTLE=3 instance: 4-cycle holds, 16-cycle latency, mid-sweep start ignored.
        b_if.exp_table = 4'b1000; b_tbl = 4'b1000;
        b_if.start = 1'b1;
        tick();
        b_if.start = 1'b0;
        lat = 0; pulses = 0;
        for (int i = 0; i < 4; i++) holds[i] = 0;
        while (!b_if.done && lat < 100) begin
            holds[b_if.vec_out]++;
            if (b_if.sample_valid) pulses++;
            b_if.start = (lat == 5);
            tick();
            lat++;
        end
        b_if.start = 1'b0;
        check("b_latency", lat, 16);
        check("b_pulses", pulses, 4);
        for (int i = 0; i < 4; i++) check($sformatf("b_hold_v%0d", i), holds[i], 4);
        check("b_result", {b_if.truth_table, b_if.mismatch_cnt, b_if.pass, b_if.vec_out},
              {4'b1000, 3'd0, 1'b1, 2'b11});

        // Random gate tables scored against a popcount reference.
        for (int r = 0; r < 8; r++) begin
            rt = 4'($urandom_range(0, 15));
            re = (r % 3 == 0) ? rt : 4'($urandom_range(0, 15));
            sweep_a(re, 1'b1, rt, lat, pulses, seq, snap);
            check($sformatf("rnd%0d_tt", r), a_if.truth_table, rt);
            check($sformatf("rnd%0d_mm", r), a_if.mismatch_cnt, 3'($countones(rt ^ re)));
            check($sformatf("rnd%0d_pass", r), a_if.pass, (rt == re));
            check($sformatf("rnd%0d_lat", r), lat, 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
